// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the writeback slice
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/riscv_load_align.sv
// rtl/riscv_load_align.sv - combinational load byte/half select and extension
module riscv_load_align
  import riscv_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[8*i_addr_lo +: 8];
    // addr_lo[0] is deliberately ignored for halfwords: misalignment is not trapped here
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'h0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'h0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/riscv_wb_stage.sv
// rtl/riscv_wb_stage.sv - writeback stage driving the regfile write port
// Optional combinational read bypass enabled by RISCV_WB_FWD_EN.
module riscv_wb_stage
  import riscv_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 64,
  parameter int TMR_W        = 8
) (
  input  logic              clk,
  input  logic              resetn,
`ifdef RISCV_WB_FWD_EN
  input  logic [REG_AW-1:0] ra0_i,
  input  logic [REG_AW-1:0] rb0_i,
  input  logic [XLEN-1:0]   ra0_value_i,
  input  logic [XLEN-1:0]   rb0_value_i,
  output logic [XLEN-1:0]   ra0_fwd_o,
  output logic [XLEN-1:0]   rb0_fwd_o,
`endif
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic              ex_wen_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [XLEN-1:0]   ex_result_i,
  input  logic              ex_is_load_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [1:0]        ex_addr_lo_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  input  logic              dmem_err_i,
  output logic              rf_wen_o,
  output logic [REG_AW-1:0] rf_rd_o,
  output logic [XLEN-1:0]   rf_wdata_o,
  output logic              busy_o,
  output logic              load_err_o
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((LOAD_TIMEOUT == 0) ? 0 : LOAD_TIMEOUT - 1);

  wb_state_e         r_state;
  logic [TMR_W-1:0]  r_timer;
  logic [REG_AW-1:0] r_rd;
  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic              r_rf_wen;
  logic [REG_AW-1:0] r_rf_rd;
  logic [XLEN-1:0]   r_rf_wdata;
  logic              r_load_err;
  logic [XLEN-1:0]   w_load_data;
  logic              w_timeout;

  riscv_load_align u_align (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr_lo),
    .i_rdata   (dmem_rdata_i),
    .o_data    (w_load_data)
  );

  assign w_timeout = (LOAD_TIMEOUT != 0) && (r_timer == TMR_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= WB_IDLE;
      r_timer    <= '0;
      r_rd       <= '0;
      r_funct3   <= '0;
      r_addr_lo  <= '0;
      r_rf_wen   <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_wdata <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_rf_wen   <= 1'b0;
      r_load_err <= 1'b0;
      case (r_state)
        WB_IDLE: begin
          if (ex_valid_i) begin
            if (ex_is_load_i) begin
              r_rd      <= ex_wen_i ? ex_rd_i : '0;
              r_funct3  <= ex_funct3_i;
              r_addr_lo <= ex_addr_lo_i;
              r_timer   <= '0;
              r_state   <= WB_WAIT;
            end else if (ex_wen_i && (ex_rd_i != '0)) begin
              r_rf_wen   <= 1'b1;
              r_rf_rd    <= ex_rd_i;
              r_rf_wdata <= ex_result_i;
            end
          end
        end
        WB_WAIT: begin
          r_timer <= r_timer + 1'b1;
          // A return coinciding with the last timeout cycle still counts as a return
          if (dmem_rvalid_i) begin
            r_state <= WB_IDLE;
            if (dmem_err_i) begin
              r_load_err <= 1'b1;
            end else if (r_rd != '0) begin
              r_rf_wen   <= 1'b1;
              r_rf_rd    <= r_rd;
              r_rf_wdata <= w_load_data;
            end
          end else if (w_timeout) begin
            r_state    <= WB_IDLE;
            r_load_err <= 1'b1;
          end
        end
        default: r_state <= WB_IDLE;
      endcase
    end
  end

  assign ex_ready_o = (r_state == WB_IDLE);
  assign busy_o     = (r_state == WB_WAIT);
  assign rf_wen_o   = r_rf_wen;
  assign rf_rd_o    = r_rf_rd;
  assign rf_wdata_o = r_rf_wdata;
  assign load_err_o = r_load_err;

`ifdef RISCV_WB_FWD_EN
  assign ra0_fwd_o = (r_rf_wen && (r_rf_rd == ra0_i) && (ra0_i != '0)) ? r_rf_wdata : ra0_value_i;
  assign rb0_fwd_o = (r_rf_wen && (r_rf_rd == rb0_i) && (rb0_i != '0)) ? r_rf_wdata : rb0_value_i;
`endif

endmodule

// File: tb/tb_riscv_wb_stage.sv
// tb/tb_riscv_wb_stage.sv - directed self-checking bench for riscv_wb_stage
module tb_riscv_wb_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid_i, ex_ready_o, ex_wen_i, ex_is_load_i;
  logic [4:0]  ex_rd_i;
  logic [31:0] ex_result_i;
  logic [2:0]  ex_funct3_i;
  logic [1:0]  ex_addr_lo_i;
  logic        dmem_rvalid_i, dmem_err_i;
  logic [31:0] dmem_rdata_i;
  logic        rf_wen_o, busy_o, load_err_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_wdata_o;
`ifdef RISCV_WB_FWD_EN
  logic [4:0]  ra0_i, rb0_i;
  logic [31:0] ra0_value_i, rb0_value_i, ra0_fwd_o, rb0_fwd_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  riscv_wb_stage #(.LOAD_TIMEOUT(8), .TMR_W(8)) dut (
    .clk           (clk),
    .resetn        (resetn),
`ifdef RISCV_WB_FWD_EN
    .ra0_i         (ra0_i),
    .rb0_i         (rb0_i),
    .ra0_value_i   (ra0_value_i),
    .rb0_value_i   (rb0_value_i),
    .ra0_fwd_o     (ra0_fwd_o),
    .rb0_fwd_o     (rb0_fwd_o),
`endif
    .ex_valid_i    (ex_valid_i),
    .ex_ready_o    (ex_ready_o),
    .ex_wen_i      (ex_wen_i),
    .ex_rd_i       (ex_rd_i),
    .ex_result_i   (ex_result_i),
    .ex_is_load_i  (ex_is_load_i),
    .ex_funct3_i   (ex_funct3_i),
    .ex_addr_lo_i  (ex_addr_lo_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .dmem_err_i    (dmem_err_i),
    .rf_wen_o      (rf_wen_o),
    .rf_rd_o       (rf_rd_o),
    .rf_wdata_o    (rf_wdata_o),
    .busy_o        (busy_o),
    .load_err_o    (load_err_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input logic wen, input logic [4:0] rd, input logic [31:0] res);
    ex_valid_i = 1'b1; ex_is_load_i = 1'b0; ex_wen_i = wen; ex_rd_i = rd; ex_result_i = res;
    step();
    ex_valid_i = 1'b0;
  endtask

  // Accept a load, wait n cycles in WAIT, then return rdata on the n-th edge.
  task automatic do_load(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd,
                         input logic wen, input int n, input logic [31:0] rdata, input logic err);
    ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_wen_i = wen; ex_rd_i = rd;
    ex_funct3_i = f3; ex_addr_lo_i = lo;
    step();
    ex_valid_i = 1'b0; ex_is_load_i = 1'b0;
    repeat (n - 1) step();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata; dmem_err_i = err;
    step();
    dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    ex_valid_i = 0; ex_wen_i = 0; ex_rd_i = 0; ex_result_i = 0; ex_is_load_i = 0;
    ex_funct3_i = 0; ex_addr_lo_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0; dmem_err_i = 0;
`ifdef RISCV_WB_FWD_EN
    ra0_i = 0; rb0_i = 0; ra0_value_i = 32'h11; rb0_value_i = 32'h22;
`endif
    step(); step();
    check_val("rst_wen", rf_wen_o, 0);
    check_val("rst_rd", rf_rd_o, 0);
    check_val("rst_wdata", rf_wdata_o, 0);
    check_val("rst_err", load_err_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_ready", ex_ready_o, 1);
    resetn = 1'b1;
    step();

    alu_op(1'b1, 5'd5, 32'hDEADBEEF);
    check_val("alu_wen", rf_wen_o, 1);
    check_val("alu_rd", rf_rd_o, 5);
    check_val("alu_wdata", rf_wdata_o, 32'hDEADBEEF);
    step();
    check_val("alu_wen_drop", rf_wen_o, 0);

    alu_op(1'b1, 5'd0, 32'h1234);
    check_val("x0_wen", rf_wen_o, 0);
    check_val("x0_rd_hold", rf_rd_o, 5);
    check_val("x0_wdata_hold", rf_wdata_o, 32'hDEADBEEF);
    step();
    check_val("x0_wen2", rf_wen_o, 0);

    ex_valid_i = 1; ex_is_load_i = 0; ex_wen_i = 1; ex_rd_i = 1; ex_result_i = 32'h111;
    step();
    check_val("b2b1_wen", rf_wen_o, 1);
    check_val("b2b1_wdata", rf_wdata_o, 32'h111);
    ex_rd_i = 2; ex_result_i = 32'h222;
    step();
    ex_valid_i = 0;
    check_val("b2b2_wen", rf_wen_o, 1);
    check_val("b2b2_rd", rf_rd_o, 2);
    check_val("b2b2_wdata", rf_wdata_o, 32'h222);

    ex_valid_i = 1; ex_is_load_i = 1; ex_wen_i = 1; ex_rd_i = 7; ex_funct3_i = 3'b000; ex_addr_lo_i = 2'd3;
    step();
    ex_valid_i = 0; ex_is_load_i = 0;
    check_val("lb_ready_wait", ex_ready_o, 0);
    check_val("lb_busy_wait", busy_o, 1);
    repeat (3) step();
    check_val("lb_busy_wait4", busy_o, 1);
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h80FF_0000;
    step();
    dmem_rvalid_i = 0;
    check_val("lb_wen", rf_wen_o, 1);
    check_val("lb_rd", rf_rd_o, 7);
    check_val("lb_wdata", rf_wdata_o, 32'hFFFFFF80);
    check_val("lb_ready", ex_ready_o, 1);
    check_val("lb_busy", busy_o, 0);

    do_load(3'b101, 2'd2, 5'd8, 1'b1, 2, 32'h8001_1234, 1'b0);
    check_val("lhu_wdata", rf_wdata_o, 32'h0000_8001);
    do_load(3'b001, 2'd2, 5'd8, 1'b1, 1, 32'h8001_1234, 1'b0);
    check_val("lh_wdata", rf_wdata_o, 32'hFFFF_8001);
    do_load(3'b001, 2'd1, 5'd8, 1'b1, 1, 32'h8001_F234, 1'b0);
    check_val("lh_lo_wdata", rf_wdata_o, 32'hFFFF_F234);
    do_load(3'b100, 2'd1, 5'd9, 1'b1, 1, 32'h8001_9234, 1'b0);
    check_val("lbu_wdata", rf_wdata_o, 32'h0000_0092);
    check_val("lbu_rd", rf_rd_o, 9);
    do_load(3'b010, 2'd3, 5'd10, 1'b1, 3, 32'hCAFE_F00D, 1'b0);
    check_val("lw_wdata", rf_wdata_o, 32'hCAFE_F00D);
    step();
    do_load(3'b010, 2'd0, 5'd11, 1'b0, 1, 32'h1357_9BDF, 1'b0);
    check_val("nowen_wen", rf_wen_o, 0);
    check_val("nowen_rd_hold", rf_rd_o, 10);

    do_load(3'b010, 2'd0, 5'd12, 1'b1, 8, 32'h0BAD_CAFE, 1'b0);
    check_val("tie_wen", rf_wen_o, 1);
    check_val("tie_err", load_err_o, 0);
    check_val("tie_wdata", rf_wdata_o, 32'h0BAD_CAFE);

    ex_valid_i = 1; ex_is_load_i = 1; ex_wen_i = 1; ex_rd_i = 13; ex_funct3_i = 3'b010;
    step();
    ex_valid_i = 0; ex_is_load_i = 0;
    for (int i = 1; i < 8; i++) begin
      step();
      check_val($sformatf("to_err_early%0d", i), load_err_o, 0);
    end
    step();
    check_val("to_err", load_err_o, 1);
    check_val("to_wen", rf_wen_o, 0);
    check_val("to_ready", ex_ready_o, 1);
    step();
    check_val("to_err_clr", load_err_o, 0);
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h7777_7777;
    step();
    dmem_rvalid_i = 0;
    check_val("stray_wen", rf_wen_o, 0);
    check_val("stray_err", load_err_o, 0);

    do_load(3'b010, 2'd0, 5'd14, 1'b1, 2, 32'h4444_4444, 1'b1);
    check_val("berr_err", load_err_o, 1);
    check_val("berr_wen", rf_wen_o, 0);
    check_val("berr_rd_hold", rf_rd_o, 12);
    step();
    check_val("berr_err_clr", load_err_o, 0);

`ifdef RISCV_WB_FWD_EN
    ra0_i = 3; ra0_value_i = 32'h11; rb0_i = 4; rb0_value_i = 32'h22;
    alu_op(1'b1, 5'd3, 32'h55);
    check_val("fwd_a_hit", ra0_fwd_o, 32'h55);
    check_val("fwd_b_miss", rb0_fwd_o, 32'h22);
    rb0_i = 3; #1;
    check_val("fwd_b_hit", rb0_fwd_o, 32'h55);
    ra0_i = 0; #1;
    check_val("fwd_a_x0", ra0_fwd_o, 32'h11);
    ra0_i = 3;
    step();
    check_val("fwd_a_stale", ra0_fwd_o, 32'h11);
`endif

    ex_valid_i = 1; ex_is_load_i = 1; ex_wen_i = 1; ex_rd_i = 15; ex_funct3_i = 3'b010;
    step();
    ex_valid_i = 0; ex_is_load_i = 0;
    step();
    check_val("mid_busy", busy_o, 1);
    resetn = 0;
    #1;
    check_val("mrst_busy", busy_o, 0);
    check_val("mrst_ready", ex_ready_o, 1);
    check_val("mrst_rd", rf_rd_o, 0);
    check_val("mrst_wdata", rf_wdata_o, 0);
    check_val("mrst_wen", rf_wen_o, 0);
    check_val("mrst_err", load_err_o, 0);
    step();
    resetn = 1;
    step();
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h9999_9999;
    step();
    dmem_rvalid_i = 0;
    check_val("post_rst_wen", rf_wen_o, 0);
    check_val("post_rst_wdata", rf_wdata_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
